picorv32_mem_slave: RTL and testbench

//   Synthesizable single-port memory slave for the PicoRV32 native memory bus
//   (mem_valid/mem_ready). It replaces the behavioural bench memory and serves

---
 rtl/picorv32_mem_slave.sv | 158 +++++++++++++++
 tb/tb_picorv32_mem_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_slave.sv
`default_nettype none
// ============================================================================
// picorv32_mem_slave: PicoRV32 native-bus memory slave with wait states,
// tohost MMIO decode and saturating traffic counters.          Rev 1.0
// ============================================================================
module picorv32_mem_slave #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        pass,
    output logic [31:0] tohost_value,
    output logic [31:0] fetch_count,
    output logic [31:0] write_count,
    output logic        err_oob,
    output logic        err_proto
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WAIT     = 2'd1;
    localparam logic [1:0]  ST_RESP     = 2'd2;
    localparam logic [29:0] TOHOST_WORD = TOHOST_ADDR[31:2];
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [29:0] req_word;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_instr;
    logic [31:0] mem [MEM_WORDS];

    logic              idle;
    logic [29:0]       cur_word;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              cur_instr;
    logic              cur_tohost;
    logic              cur_in_range;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_idx;
    logic              go_resp;
    logic [31:0]       tohost_merged;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];
    assign mem_ready        = (state == ST_RESP);

    // With zero wait states the commit happens on the capture edge itself, so
    // the request is taken straight from the bus rather than the capture regs.
    always_comb begin
        idle          = (state == ST_IDLE);
        cur_word      = idle ? mem_addr[31:2] : req_word;
        cur_wdata     = idle ? mem_wdata      : req_wdata;
        cur_wstrb     = idle ? mem_wstrb      : req_wstrb;
        cur_instr     = idle ? mem_instr      : req_instr;
        cur_tohost    = (cur_word == TOHOST_WORD);
        cur_in_range  = ({2'b00, cur_word} < 32'(MEM_WORDS));
        cur_idx       = cur_word[ADDR_W-1:0];
        cur_write     = |cur_wstrb;
        go_resp       = mem_valid && ((idle && WAIT_CYCLES == 0) ||
                                      (state == ST_WAIT && wait_cnt == 4'd0));
        tohost_merged = tohost_value;
        for (int i = 0; i < 4; i++) begin
            if (cur_wstrb[i]) tohost_merged[8*i +: 8] = cur_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && go_resp && cur_write && !cur_tohost && cur_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            req_word     <= 30'd0;
            req_wdata    <= 32'd0;
            req_wstrb    <= 4'd0;
            req_instr    <= 1'b0;
            mem_rdata    <= 32'd0;
            done         <= 1'b0;
            pass         <= 1'b0;
            tohost_value <= 32'd0;
            fetch_count  <= 32'd0;
            write_count  <= 32'd0;
            err_oob      <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        req_word  <= mem_addr[31:2];
                        req_wdata <= mem_wdata;
                        req_wstrb <= mem_wstrb;
                        req_instr <= mem_instr;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid) begin
                        err_proto <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (go_resp) begin
                if (cur_tohost) begin
                    if (cur_write) begin
                        tohost_value <= tohost_merged;
                        done         <= 1'b1;
                        pass         <= (tohost_merged == 32'h1);
                    end else begin
                        mem_rdata <= tohost_value;
                    end
                end else if (cur_in_range) begin
                    if (!cur_write) mem_rdata <= mem[cur_idx];
                end else begin
                    err_oob <= 1'b1;
                    if (!cur_write) mem_rdata <= 32'hDEAD_BEEF;
                end
                if (!cur_write && cur_instr && fetch_count != 32'hFFFF_FFFF)
                    fetch_count <= fetch_count + 32'd1;
                if (cur_write && write_count != 32'hFFFF_FFFF)
                    write_count <= write_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_slave.sv
`default_nettype none
// ============================================================================
// tb_picorv32_mem_slave: scoreboard bench for picorv32_mem_slave.   Rev 1.0
// ============================================================================
module tb_picorv32_mem_slave;

  localparam int          WAITS  = 2;
  localparam logic [31:0] TOHOST = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, done, pass, err_oob, err_proto;
  logic [31:0] mem_rdata, tohost_value, fetch_count, write_count;

  logic        z_valid, z_instr;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_wstrb;
  logic        z_ready, z_done, z_pass, z_oob, z_proto;
  logic [31:0] z_rdata, z_tohost, z_fc, z_wc;

  picorv32_mem_slave #(.WAIT_CYCLES(WAITS), .TOHOST_ADDR(TOHOST)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .done(done), .pass(pass),
    .tohost_value(tohost_value), .fetch_count(fetch_count),
    .write_count(write_count), .err_oob(err_oob), .err_proto(err_proto));

  picorv32_mem_slave #(.WAIT_CYCLES(0), .TOHOST_ADDR(TOHOST)) dut0 (
    .clk(clk), .reset(reset), .mem_valid(z_valid), .mem_instr(z_instr),
    .mem_addr(z_addr), .mem_wdata(z_wdata), .mem_wstrb(z_wstrb),
    .mem_ready(z_ready), .mem_rdata(z_rdata), .done(z_done), .pass(z_pass),
    .tohost_value(z_tohost), .fetch_count(z_fc),
    .write_count(z_wc), .err_oob(z_oob), .err_proto(z_proto));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain word array plus architectural flags.
  typedef struct {
    logic [31:0] rdata, fc, wc, tv;
    logic        dn, ps, oob;
    int          issue;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_mem [1024];
  logic [31:0] m_tohost, m_fc, m_wc, m_last;
  logic        m_done, m_pass, m_oob;

  task automatic model_reset();
    m_tohost = 0; m_fc = 0; m_wc = 0; m_last = 0;
    m_done = 0; m_pass = 0; m_oob = 0;
  endtask

  task automatic model_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ins, output exp_t e);
    logic [31:0] w;
    w = a >> 2;
    if (w == (TOHOST >> 2)) begin
      if (s != 0) begin
        for (int i = 0; i < 4; i++) if (s[i]) m_tohost[8*i +: 8] = d[8*i +: 8];
        m_done = 1;
        m_pass = (m_tohost == 32'h1);
      end else m_last = m_tohost;
    end else if (w < 1024) begin
      if (s != 0) begin
        for (int i = 0; i < 4; i++) if (s[i]) m_mem[w][8*i +: 8] = d[8*i +: 8];
      end else m_last = m_mem[w];
    end else begin
      m_oob = 1;
      if (s == 0) m_last = 32'hDEAD_BEEF;
    end
    if (s == 0 && ins && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (s != 0 && m_wc != 32'hFFFF_FFFF) m_wc++;
    e.rdata = m_last; e.fc = m_fc; e.wc = m_wc; e.tv = m_tohost;
    e.dn = m_done; e.ps = m_pass; e.oob = m_oob; e.issue = 0;
  endtask

  task automatic bus_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    model_req(a, d, s, ins, e);
    e.issue = cyc;
    sbq.push_back(e);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_ready) break;
    end
    if (k == 20) begin
      check("ready_timeout", 32'(k), 32'(WAITS + 1));
      sbq.delete();
    end
    @(posedge clk); #1;
    mem_valid = 0;
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (mem_ready && !reset) begin
      if (sbq.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("latency", 32'(cyc - e.issue), 32'(WAITS + 1));
        check("rdata", mem_rdata, e.rdata);
        check("fetch_count", fetch_count, e.fc);
        check("write_count", write_count, e.wc);
        check("tohost_value", tohost_value, e.tv);
        check("flags", {29'd0, done, pass, err_oob}, {29'd0, e.dn, e.ps, e.oob});
        check("err_proto", {31'd0, err_proto}, 32'd0);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [31:0] a, d, old4;
    logic [3:0]  s;
    int          r, nready, last_c, first_c;

    reset = 1; mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    z_valid = 0; z_instr = 0; z_addr = 0; z_wdata = 0; z_wstrb = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_rdata", {mem_ready, mem_rdata[30:0]}, 32'd0);
    check("reset_flags", {28'd0, done, pass, err_oob, err_proto}, 32'd0);
    check("reset_counters", fetch_count | write_count | tohost_value, 32'd0);
    check("reset_dut0", {z_ready, z_done, z_pass, z_oob, z_proto, 27'd0} | z_fc | z_wc, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 32; i++) begin
      d = (i == 1) ? 32'h0000_0013 : (i == 2) ? 32'h1122_3344 : $urandom;
      bus_req(32'(i * 4), d, 4'hF, 1'b0);
    end

    bus_req(32'h4, 0, 4'h0, 1'b1);
    check("fetch_word1", mem_rdata, 32'h0000_0013);
    check("fetch_count_1", fetch_count, 32'd1);

    bus_req(32'h8, 32'hAABB_CCDD, 4'b0100, 1'b0);
    check("write_keeps_rdata", mem_rdata, 32'h0000_0013);
    bus_req(32'h8, 0, 4'h0, 1'b0);
    check("byte_merge", mem_rdata, 32'h11BB_3344);

    bus_req(TOHOST, 32'h1, 4'hF, 1'b0);
    check("tohost_pass", {29'd0, done, pass, 1'b0}, 32'd6);
    check("tohost_val1", tohost_value, 32'h1);
    bus_req(TOHOST, 32'h5, 4'hF, 1'b0);
    check("tohost_fail", {29'd0, done, pass, 1'b0}, 32'd4);

    bus_req(32'h0000_1000, 0, 4'h0, 1'b0);
    check("oob_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("oob_flag", {31'd0, err_oob}, 32'd1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      else if (r == 7) a = TOHOST + 32'($urandom_range(0, 3));
      else if (r == 8) a = 32'h0000_1000 + 32'($urandom_range(0, 31)) * 4;
      else             a = 32'h8000_0000 | (32'($urandom_range(0, 1023)) * 4);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus_req(a, $urandom, s, 1'($urandom_range(0, 1)));
    end

    // Dropping valid mid-wait must abort silently and flag the protocol error.
    @(posedge clk); #1;
    mem_valid = 1; mem_addr = 32'h0; mem_wstrb = 4'h0; mem_instr = 1;
    @(posedge clk); #1;
    mem_valid = 0;
    nready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) nready++;
    end
    check("proto_no_ready", 32'(nready), 32'd0);
    check("proto_flag", {31'd0, err_proto}, 32'd1);

    // Reset in the middle of a write's wait states.
    old4 = m_mem[4];
    @(posedge clk); #1;
    mem_valid = 1; mem_addr = 32'h10; mem_wdata = ~old4; mem_wstrb = 4'hF; mem_instr = 0;
    @(posedge clk); #1;
    reset = 1; mem_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_abort_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_clears_proto", {31'd0, err_proto}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    bus_req(32'h10, 0, 4'h0, 1'b0);
    check("reset_no_write", mem_rdata, old4);

    // Zero-wait slave with valid held high: a pulse every other cycle.
    @(posedge clk); #1;
    z_valid = 1; z_instr = 1; z_addr = 32'h40; z_wstrb = 0;
    first_c = cyc; last_c = -1; nready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (z_ready) begin
        if (last_c < 0) check("zw_latency", 32'(cyc - first_c), 32'd1);
        else            check("zw_spacing", 32'(cyc - last_c), 32'd2);
        last_c = cyc;
        nready++;
      end
    end
    @(posedge clk); #1;
    z_valid = 0;
    check("zw_pulses", 32'(nready), 32'd6);
    @(negedge clk);
    check("zw_fetch_count", z_fc, 32'd6);

    repeat (4) @(posedge clk);
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
